access_code_ctrl: RTL and testbench

Parametrised successor to the team's digit-count / door-open FSM pair.
- Accepts a keypad code of CODE_LEN digits, each DIGIT_W bits wide, and compares it against a reference code on a start strobe.
- On a match, opens the gate for a timed window; on a mismatch, counts the failure.
- After MAX_FAILS consecutive failures, enters a timed lockout.
- Sits between the keypad debouncer and the gate actuator driver.

---
 rtl/access_code_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_access_code_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/access_code_ctrl.sv
// Keypad access controller: code compare, timed gate window, fail lockout.
// Define ACCESS_TIMEOUT_EN to abort stalled code entry after IDLE_TIMEOUT.
module access_code_ctrl #(
  parameter int CODE_LEN     = 4,
  parameter int DIGIT_W      = 4,
  parameter int OPEN_CYCLES  = 16,
  parameter int MAX_FAILS    = 3,
  parameter int LOCK_CYCLES  = 32,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               digit_valid,
  input  logic [DIGIT_W-1:0]                 digit,
  input  logic                               start,
  input  logic [CODE_LEN*DIGIT_W-1:0]        code_ref,
  output logic                               gate_open,
  output logic                               locked,
  output logic                               fail_pulse,
  output logic [$clog2(CODE_LEN+1)-1:0]      digit_count,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count
);

  localparam int CLW  = CODE_LEN * DIGIT_W;
  localparam int CW   = $clog2(CODE_LEN + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES
                                                    : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] C_FULL = CW'(CODE_LEN);
  localparam logic [FW-1:0] C_FMAX = FW'(MAX_FAILS);
  localparam logic [TW-1:0] C_OPEN = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] C_LOCK = TW'(LOCK_CYCLES - 1);

  if (CODE_LEN < 2 || CODE_LEN > 8 || OPEN_CYCLES < 1 ||
      MAX_FAILS < 1 || LOCK_CYCLES < 1 || IDLE_TIMEOUT < 1)
  begin : g_bad_params
    $error("access_code_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE, S_ENTRY, S_OPEN, S_LOCK
  } state_t;

  state_t          r_state,  w_state_n;
  logic [CLW-1:0]  r_code,   w_code_n;
  logic [CW-1:0]   r_dcnt,   w_dcnt_n;
  logic [FW-1:0]   r_fcnt,   w_fcnt_n;
  logic [TW-1:0]   r_timer,  w_timer_n;
  logic            r_gate,   w_gate_n;
  logic            r_lock,   w_lock_n;
  logic            r_fpulse, w_fpulse_n;
  logic            w_match;
  logic            w_reject;
  logic [FW-1:0]   w_fcnt_inc;

`ifdef ACCESS_TIMEOUT_EN
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IW-1:0] C_IDLE = IW'(IDLE_TIMEOUT - 1);
  logic [IW-1:0] r_idle, w_idle_n;
`endif

  assign w_match    = (r_dcnt == C_FULL) && (r_code == code_ref);
  assign w_fcnt_inc = r_fcnt + 1'b1;

  always_comb begin
    w_state_n  = r_state;
    w_code_n   = r_code;
    w_dcnt_n   = r_dcnt;
    w_fcnt_n   = r_fcnt;
    w_timer_n  = r_timer;
    w_gate_n   = r_gate;
    w_lock_n   = r_lock;
    w_fpulse_n = 1'b0;
    w_reject   = 1'b0;
`ifdef ACCESS_TIMEOUT_EN
    w_idle_n   = r_idle;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_reject = 1'b1;
        end else if (digit_valid) begin
          w_code_n  = CLW'(digit);
          w_dcnt_n  = CW'(1);
          w_state_n = S_ENTRY;
`ifdef ACCESS_TIMEOUT_EN
          w_idle_n  = '0;
`endif
        end
      end
      S_ENTRY: begin
        if (start) begin
          w_code_n = '0;
          w_dcnt_n = '0;
          if (w_match) begin
            w_state_n = S_OPEN;
            w_gate_n  = 1'b1;
            w_timer_n = C_OPEN;
            w_fcnt_n  = '0;
          end else begin
            w_reject = 1'b1;
          end
        end else if (digit_valid) begin
          // A full register holds its code; extra keypresses are dropped.
          if (r_dcnt != C_FULL) begin
            w_code_n = {r_code[CLW-DIGIT_W-1:0], digit};
            w_dcnt_n = r_dcnt + 1'b1;
          end
`ifdef ACCESS_TIMEOUT_EN
          w_idle_n = '0;
        end else if (r_idle == C_IDLE) begin
          w_code_n  = '0;
          w_dcnt_n  = '0;
          w_state_n = S_IDLE;
        end else begin
          w_idle_n = r_idle + 1'b1;
`endif
        end
      end
      S_OPEN: begin
        if (r_timer == '0) begin
          w_gate_n  = 1'b0;
          w_state_n = S_IDLE;
        end else begin
          w_timer_n = r_timer - 1'b1;
        end
      end
      S_LOCK: begin
        if (r_timer == '0) begin
          w_lock_n  = 1'b0;
          w_fcnt_n  = '0;
          w_state_n = S_IDLE;
        end else begin
          w_timer_n = r_timer - 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_reject) begin
      w_fpulse_n = 1'b1;
      w_fcnt_n   = w_fcnt_inc;
      if (w_fcnt_inc == C_FMAX) begin
        w_state_n = S_LOCK;
        w_lock_n  = 1'b1;
        w_timer_n = C_LOCK;
      end else begin
        w_state_n = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_code   <= '0;
      r_dcnt   <= '0;
      r_fcnt   <= '0;
      r_timer  <= '0;
      r_gate   <= 1'b0;
      r_lock   <= 1'b0;
      r_fpulse <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_code   <= w_code_n;
      r_dcnt   <= w_dcnt_n;
      r_fcnt   <= w_fcnt_n;
      r_timer  <= w_timer_n;
      r_gate   <= w_gate_n;
      r_lock   <= w_lock_n;
      r_fpulse <= w_fpulse_n;
    end
  end

`ifdef ACCESS_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_idle <= '0;
    else        r_idle <= w_idle_n;
  end
`endif

  assign gate_open   = r_gate;
  assign locked      = r_lock;
  assign fail_pulse  = r_fpulse;
  assign digit_count = r_dcnt;
  assign fail_count  = r_fcnt;

endmodule

// File: tb/tb_access_code_ctrl.sv
// Directed bench for access_code_ctrl with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_access_code_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = '0;
  logic        start = 1'b0;
  logic [15:0] code_ref = 16'h1234;
  logic        gate_open;
  logic        locked;
  logic        fail_pulse;
  logic [2:0]  digit_count;
  logic [1:0]  fail_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  access_code_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .digit_valid (digit_valid),
    .digit       (digit),
    .start       (start),
    .code_ref    (code_ref),
    .gate_open   (gate_open),
    .locked      (locked),
    .fail_pulse  (fail_pulse),
    .digit_count (digit_count),
    .fail_count  (fail_count)
  );

  // Called at a falling edge; the key is captured by the next rising edge.
  task automatic press(input logic [3:0] d);
    digit_valid = 1'b1;
    digit = d;
    @(negedge clk);
    digit_valid = 1'b0;
  endtask

  task automatic strobe();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic enter(input logic [15:0] c);
    press(c[15:12]);
    press(c[11:8]);
    press(c[7:4]);
    press(c[3:0]);
  endtask

  // Cycles the output stays high from now on; overlap with the other
  // output is recorded as a flag.
  task automatic run_gate(output int n, output bit both);
    n = 0;
    both = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!gate_open) break;
      if (locked) both = 1'b1;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_lock(output int n, output bit both);
    n = 0;
    both = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!locked) break;
      if (gate_open) both = 1'b1;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({gate_open, locked, fail_pulse, digit_count, fail_count} !== 8'h00)
    begin
      n_bad++;
      $display("FAIL reset_outputs got %b want 00000000",
               {gate_open, locked, fail_pulse, digit_count, fail_count});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_open();
    int n;
    bit both;
    enter(16'h1234);
    n_cmp++;
    if (digit_count !== 3'd4) begin
      n_bad++;
      $display("FAIL open_dcnt4 got %0d want 4", digit_count);
    end
    n_cmp++;
    if (gate_open !== 1'b0) begin
      n_bad++;
      $display("FAIL open_early got %0b want 0", gate_open);
    end
    strobe();
    n_cmp++;
    if (digit_count !== 3'd0 || fail_count !== 2'd0) begin
      n_bad++;
      $display("FAIL open_counts got %0d/%0d want 0/0",
               digit_count, fail_count);
    end
    run_gate(n, both);
    n_cmp++;
    if (n !== 16) begin
      n_bad++;
      $display("FAIL open_len got %0d want 16", n);
    end
    n_cmp++;
    if (both !== 1'b0) begin
      n_bad++;
      $display("FAIL open_exclusive got %0b want 0", both);
    end
  endtask

  task automatic test_lockout();
    int n;
    bit both;
    for (int k = 1; k <= 3; k++) begin
      enter(16'h1235);
      strobe();
      n_cmp++;
      if (fail_pulse !== 1'b1 || fail_count !== 2'(k) || gate_open !== 1'b0)
      begin
        n_bad++;
        $display("FAIL bad_code%0d got p=%0b f=%0d g=%0b want p=1 f=%0d g=0",
                 k, fail_pulse, fail_count, gate_open, k);
      end
      n_cmp++;
      if (locked !== (k == 3)) begin
        n_bad++;
        $display("FAIL bad_lock%0d got %0b want %0b", k, locked, k == 3);
      end
      if (k < 3) begin
        @(negedge clk);
        n_cmp++;
        if (fail_pulse !== 1'b0) begin
          n_bad++;
          $display("FAIL pulse_width%0d got 1 want 0", k);
        end
      end
    end
    run_lock(n, both);
    n_cmp++;
    if (n !== 32) begin
      n_bad++;
      $display("FAIL lock_len got %0d want 32", n);
    end
    n_cmp++;
    if (both !== 1'b0 || fail_count !== 2'd0) begin
      n_bad++;
      $display("FAIL lock_exit got both=%0b f=%0d want both=0 f=0",
               both, fail_count);
    end
  endtask

  task automatic test_short_code();
    int n;
    bit both;
    press(4'd1);
    press(4'd2);
    press(4'd3);
    strobe();
    n_cmp++;
    if (fail_pulse !== 1'b1 || fail_count !== 2'd1) begin
      n_bad++;
      $display("FAIL short_reject got p=%0b f=%0d want p=1 f=1",
               fail_pulse, fail_count);
    end
    enter(16'h1234);
    press(4'd9);
    n_cmp++;
    if (digit_count !== 3'd4) begin
      n_bad++;
      $display("FAIL extra_digit got %0d want 4", digit_count);
    end
    strobe();
    run_gate(n, both);
    n_cmp++;
    if (n !== 16 || fail_count !== 2'd0) begin
      n_bad++;
      $display("FAIL extra_open got n=%0d f=%0d want n=16 f=0",
               n, fail_count);
    end
  endtask

  task automatic test_start_with_digit();
    int n;
    bit both;
    press(4'd1);
    press(4'd2);
    press(4'd3);
    digit_valid = 1'b1;
    digit = 4'd4;
    strobe();
    digit_valid = 1'b0;
    n_cmp++;
    if (fail_pulse !== 1'b1 || digit_count !== 3'd0 ||
        fail_count !== 2'd1) begin
      n_bad++;
      $display("FAIL collide got p=%0b d=%0d f=%0d want p=1 d=0 f=1",
               fail_pulse, digit_count, fail_count);
    end
    @(negedge clk);
    n_cmp++;
    if (digit_count !== 3'd0 || gate_open !== 1'b0) begin
      n_bad++;
      $display("FAIL collide_after got d=%0d g=%0b want d=0 g=0",
               digit_count, gate_open);
    end
    // Start alone from IDLE is also a rejection.
    strobe();
    n_cmp++;
    if (fail_pulse !== 1'b1 || fail_count !== 2'd2) begin
      n_bad++;
      $display("FAIL idle_start got p=%0b f=%0d want p=1 f=2",
               fail_pulse, fail_count);
    end
    enter(16'h1234);
    strobe();
    run_gate(n, both);
    n_cmp++;
    if (n !== 16 || fail_count !== 2'd0) begin
      n_bad++;
      $display("FAIL collide_recover got n=%0d f=%0d want n=16 f=0",
               n, fail_count);
    end
  endtask

  task automatic test_reset_mid_open();
    int n;
    bit both;
    enter(16'h1235);
    strobe();
    enter(16'h1234);
    strobe();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (gate_open !== 1'b1) begin
      n_bad++;
      $display("FAIL midopen_pre got %0b want 1", gate_open);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({gate_open, locked, fail_pulse, digit_count, fail_count} !== 8'h00)
    begin
      n_bad++;
      $display("FAIL async_reset got %b want 00000000",
               {gate_open, locked, fail_pulse, digit_count, fail_count});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    enter(16'h1234);
    strobe();
    run_gate(n, both);
    n_cmp++;
    if (n !== 16) begin
      n_bad++;
      $display("FAIL reopen got %0d want 16", n);
    end
  endtask

`ifdef ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bit both;
    bit saw;
    saw = 1'b0;
    press(4'd1);
    press(4'd2);
    for (int i = 0; i < 63; i++) begin
      @(negedge clk);
      if (fail_pulse) saw = 1'b1;
    end
    n_cmp++;
    if (digit_count !== 3'd2) begin
      n_bad++;
      $display("FAIL timeout_early got %0d want 2", digit_count);
    end
    @(negedge clk);
    if (fail_pulse) saw = 1'b1;
    n_cmp++;
    if (digit_count !== 3'd0 || saw !== 1'b0 || fail_count !== 2'd0) begin
      n_bad++;
      $display("FAIL timeout_abort got d=%0d p=%0b f=%0d want 0/0/0",
               digit_count, saw, fail_count);
    end
    press(4'd1);
    press(4'd2);
    repeat (63) @(negedge clk);
    press(4'd3);
    press(4'd4);
    strobe();
    run_gate(n, both);
    n_cmp++;
    if (n !== 16) begin
      n_bad++;
      $display("FAIL timeout_63 got %0d want 16", n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_open();
    test_lockout();
    test_short_code();
    test_start_with_digit();
    test_reset_mid_open();
`ifdef ACCESS_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
